mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Main sequencer for the multicycle RV32I core. Moore FSM over opcode classes that drives every datapath enable and mux select. It also evaluates all six branch conditions from the ALU flags, so branch and jump decoding is folded into the controller. Sits between the instruction register/flag outputs and the shared PC/ALU/register-file/memory datapath.

## Interface
- STATE_W, 4, width of state register (encodings from package)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- op  in  7  instruction opcode from IR
- funct3  in  3  instruction funct3 from IR
- Zero, Negative, Carry, Overflow  in  1 each  ALU flags of current cycle
- mem_ready  in  1  memory access complete (only with MCCTRL_MEMWAIT_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- MemWrite  out  1  data memory write
- IRWrite  out  1  IR/OldPC load
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
- illegal_op  out  1  one-cycle pulse in DECODE for unknown opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (target → ALUOut). Transitions:
  - lw/sw (0000011/0100011) → MEMADR
  - R-type 0110011 → EXECR
  - I-ALU 0010011 → EXECI
  - branch 1100011 → BRANCH
  - jal 1101111 → JAL
  - jalr 1100111 → JALR
  - other → FETCH with illegal_op=1
- MEMADR: A=10, B=01, ALUOp=00 → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 → FETCH.
- EXECR: A=10, B=00, ALUOp=10 → ALUWB.
- EXECI: A=10, B=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00; PCWrite=take → FETCH.
  - take by funct3: 000 Zero; 001 ~Zero; 100 N^V; 101 ~(N^V); 110 ~Carry; 111 Carry; 010/011 0.
  - Carry convention: Carry=1 means no borrow.
- JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB.
- JALR: A=10, B=01, ALUOp=00 (rs1+imm → ALUOut) → JALR2.
- JALR2: ResultSrc=00, PCWrite=1, A=01, B=10, ALUOp=00 → ALUWB.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are combinational from the state register. The only exception is BRANCH PCWrite, which also depends on flags and funct3.
- Reset: state=FETCH immediately. While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced 0. Selects show FETCH values.
- Reset mid-instruction aborts it. No write enable is asserted in the cycle reset is high.
- Cycle counts (no wait): lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5.
- op and funct3 are sampled only in DECODE, BRANCH and MEMADR. The IR is stable after FETCH.

## Configuration
- MCCTRL_MEMWAIT_EN defined:
  - mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - In FETCH, IRWrite/PCWrite assert only in the cycle mem_ready=1. MemWrite stays asserted while waiting.
- Undefined: the port is absent and mem_ready is treated as constant 1.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (STATE_W bits)
  - opcode constants
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings
  - funct3 branch constants
- Sub-module branch_cond: combinational; funct3 + flags → take. Instantiated once.

## Test plan
- Reset asserted mid-MEMWRITE (sw) → MemWrite drops the same cycle, state=FETCH; after release, first cycle has IRWrite=1, PCWrite=1.
- add (op 0110011) → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4, ALUOp=10 in cycle 3.
- lw → 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 with RegWrite=1 in MEMWB; sw → MemWrite=1 exactly one cycle.
- Branch sweep: beq Zero=1 → PCWrite=1; blt N=1,V=1 → 0; bltu Carry=0 → 1; bgeu Carry=0 → 0; funct3=010 → 0.
- jalr → 5 cycles, PCWrite in JALR2 with ResultSrc=00, RegWrite in ALUWB; op=0000000 → illegal_op pulse, back to FETCH after 2 cycles.
- With MCCTRL_MEMWAIT_EN, mem_ready=0 for 3 cycles in FETCH → IRWrite=0 and state held, then IRWrite=1 on the ready cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, opcodes, mux/ALU select encodings and branch funct3 codes
package mc_ctrl_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2
  } state_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR/flag inputs and datapath controls of the sequencer
// MCCTRL_MEMWAIT_EN adds the mem_ready handshake input.
interface mc_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, Negative, Carry, Overflow;
`ifdef MCCTRL_MEMWAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
`ifdef MCCTRL_MEMWAIT_EN
  modport master (input op, funct3, Zero, Negative, Carry, Overflow, mem_ready,
                  output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp);
  modport slave (output op, funct3, Zero, Negative, Carry, Overflow, mem_ready,
                 input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp);
`else
  modport master (input op, funct3, Zero, Negative, Carry, Overflow,
                  output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp);
  modport slave (output op, funct3, Zero, Negative, Carry, Overflow,
                 input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp);
`endif
endinterface

// File: rtl/mc_ctrl_branch_cond.sv
// branch_cond: branch-taken decision from funct3 and the ALU flags of rs1-rs2
// Carry=1 means no borrow, so unsigned less-than is ~Carry.
module branch_cond
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_neg,
  input  logic       i_carry,
  input  logic       i_ovf,
  output logic       o_take
);
  logic w_lt;
  assign w_lt = i_neg ^ i_ovf;
  always_comb begin
    o_take = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_take = i_zero;
      F3_BNE:  o_take = ~i_zero;
      F3_BLT:  o_take = w_lt;
      F3_BGE:  o_take = ~w_lt;
      F3_BLTU: o_take = ~i_carry;
      F3_BGEU: o_take = i_carry;
      default: o_take = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore sequencer for the multicycle RV32I core driving all datapath enables and selects
// MCCTRL_MEMWAIT_EN makes FETCH/MEMREAD/MEMWRITE hold until mem_ready.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);
  state_t     r_state, w_next;
  logic       w_ready, w_take;
  logic       w_pcw, w_adr, w_mw, w_irw, w_rw, w_ill;
  logic [1:0] w_res, w_a, w_b, w_alu;
`ifdef MCCTRL_MEMWAIT_EN
  assign w_ready = bus.mem_ready;
`else
  assign w_ready = 1'b1;
`endif
  branch_cond u_bc (
    .i_funct3(bus.funct3), .i_zero(bus.Zero), .i_neg(bus.Negative),
    .i_carry(bus.Carry), .i_ovf(bus.Overflow), .o_take(w_take)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  always_comb begin
    w_next = S_FETCH;
    w_pcw  = 1'b0;
    w_adr  = 1'b0;
    w_mw   = 1'b0;
    w_irw  = 1'b0;
    w_rw   = 1'b0;
    w_ill  = 1'b0;
    w_res  = RES_ALUOUT;
    w_a    = SRCA_PC;
    w_b    = SRCB_RS2;
    w_alu  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw  = w_ready;
        w_pcw  = w_ready;
        w_res  = RES_ALURES;
        w_b    = SRCB_FOUR;
        w_next = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_a = SRCA_OLDPC;
        w_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          default:      w_ill  = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_a    = SRCA_RS1;
        w_b    = SRCB_IMM;
        w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr  = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_res = RES_DATA;
        w_rw  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr  = 1'b1;
        w_mw   = 1'b1;
        w_next = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_a    = SRCA_RS1;
        w_alu  = ALU_FUNCT;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_a    = SRCA_RS1;
        w_b    = SRCB_IMM;
        w_alu  = ALU_FUNCT;
        w_next = S_ALUWB;
      end
      S_ALUWB: w_rw = 1'b1;
      S_BRANCH: begin
        w_a   = SRCA_RS1;
        w_alu = ALU_SUB;
        w_pcw = w_take;
      end
      S_JAL, S_JALR2: begin
        w_a    = SRCA_OLDPC;
        w_b    = SRCB_FOUR;
        w_pcw  = 1'b1;
        w_next = S_ALUWB;
      end
      S_JALR: begin
        w_a    = SRCA_RS1;
        w_b    = SRCB_IMM;
        w_next = S_JALR2;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // write enables are killed while reset is high so an aborted instruction leaves no side effect
  assign bus.PCWrite    = w_pcw & ~reset;
  assign bus.IRWrite    = w_irw & ~reset;
  assign bus.MemWrite   = w_mw  & ~reset;
  assign bus.RegWrite   = w_rw  & ~reset;
  assign bus.illegal_op = w_ill & ~reset;
  assign bus.AdrSrc     = w_adr;
  assign bus.ResultSrc  = w_res;
  assign bus.ALUSrcA    = w_a;
  assign bus.ALUSrcB    = w_b;
  assign bus.ALUOp      = w_alu;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream checked per cycle against an instruction-level model
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [13:0] outv;
  mc_ctrl_if bus();
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign outv = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal_op};
  localparam logic [13:0] EN_MASK = 14'b10_0100_0000_0000;
`ifdef MCCTRL_MEMWAIT_EN
  int fetch_wait = -1;
`endif

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] v(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] res, a, b, alu, input logic ill);
    return {pcw, adr, mw, irw, rw, res, a, b, alu, ill};
  endfunction

  function automatic logic known(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR};
  endfunction

  // flags come from a real rs1-rs2 subtraction; branch outcome from plain comparisons
  task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b, input int max_steps);
    logic [13:0] q[$];
    logic [31:0] d;
    logic take;
    logic [13:0] fe, aw;
    d = a - b;
    case (f3)
      3'd0: take = (a == b);
      3'd1: take = (a != b);
      3'd4: take = ($signed(a) < $signed(b));
      3'd5: take = ($signed(a) >= $signed(b));
      3'd6: take = (a < b);
      3'd7: take = (a >= b);
      default: take = 1'b0;
    endcase
    bus.op = opc;
    bus.funct3 = f3;
    bus.Zero = (d == 32'd0);
    bus.Negative = d[31];
    bus.Carry = (a >= b);
    bus.Overflow = (a[31] != b[31]) && (d[31] != a[31]);
    fe = v(1, 0, 0, 1, 0, RES_ALURES, SRCA_PC, SRCB_FOUR, ALU_ADD, 0);
    aw = v(0, 0, 0, 0, 1, RES_ALUOUT, SRCA_PC, SRCB_RS2, ALU_ADD, 0);
    q.push_back(fe);
    q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_OLDPC, SRCB_IMM, ALU_ADD, !known(opc)));
    case (opc)
      OP_LW: begin
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_RS1, SRCB_IMM, ALU_ADD, 0));
        q.push_back(v(0, 1, 0, 0, 0, RES_ALUOUT, 2'b00, 2'b00, 2'b00, 0));
        q.push_back(v(0, 0, 0, 0, 1, RES_DATA, 2'b00, 2'b00, 2'b00, 0));
      end
      OP_SW: begin
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_RS1, SRCB_IMM, ALU_ADD, 0));
        q.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      OP_R: begin
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_RS1, SRCB_RS2, ALU_FUNCT, 0));
        q.push_back(aw);
      end
      OP_I: begin
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_RS1, SRCB_IMM, ALU_FUNCT, 0));
        q.push_back(aw);
      end
      OP_BR: q.push_back(v(take, 0, 0, 0, 0, RES_ALUOUT, SRCA_RS1, SRCB_RS2, ALU_SUB, 0));
      OP_JAL: begin
        q.push_back(v(1, 0, 0, 0, 0, RES_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALU_ADD, 0));
        q.push_back(aw);
      end
      OP_JALR: begin
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, SRCA_RS1, SRCB_IMM, ALU_ADD, 0));
        q.push_back(v(1, 0, 0, 0, 0, RES_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALU_ADD, 0));
        q.push_back(aw);
      end
      default: ;
    endcase
    foreach (q[i]) begin
      if (max_steps >= 0 && i >= max_steps) break;
`ifdef MCCTRL_MEMWAIT_EN
      // FETCH has IRWrite set, memory states have AdrSrc set: those are the ones that wait
      if (q[i][10] || q[i][12]) begin
        int nw;
        nw = (q[i][10] && fetch_wait >= 0) ? fetch_wait : int'($urandom_range(0, 2));
        for (int w = 0; w < nw; w++) begin
          bus.mem_ready = 1'b0;
          @(negedge clk);
          chk({name, "_wait"}, outv, q[i][10] ? (q[i] & ~EN_MASK) : q[i]);
          @(posedge clk);
          #1;
        end
        bus.mem_ready = 1'b1;
      end
`endif
      @(negedge clk);
      chk(name, outv, q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] opc;
    logic [31:0] a, b;
    bus.op = 7'd0;
    bus.funct3 = 3'd0;
    bus.Zero = 1'b0;
    bus.Negative = 1'b0;
    bus.Carry = 1'b0;
    bus.Overflow = 1'b0;
`ifdef MCCTRL_MEMWAIT_EN
    bus.mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", outv, v(0, 0, 0, 0, 0, RES_ALURES, SRCA_PC, SRCB_FOUR, ALU_ADD, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    run("add", OP_R, 3'd0, 32'd5, 32'd7, -1);
    run("addi", OP_I, 3'd0, 32'd5, 32'd7, -1);
    run("lw", OP_LW, 3'd2, 32'd0, 32'd0, -1);
    run("sw", OP_SW, 3'd2, 32'd0, 32'd0, -1);
    run("beq_t", OP_BR, F3_BEQ, 32'd9, 32'd9, -1);
    run("blt_nv", OP_BR, F3_BLT, 32'h7fffffff, 32'hffffffff, -1);
    run("bltu_c0", OP_BR, F3_BLTU, 32'd1, 32'd2, -1);
    run("bgeu_c0", OP_BR, F3_BGEU, 32'd1, 32'd2, -1);
    run("br_010", OP_BR, 3'b010, 32'd3, 32'd3, -1);
    run("jal", OP_JAL, 3'd0, 32'd0, 32'd0, -1);
    run("jalr", OP_JALR, 3'd0, 32'd0, 32'd0, -1);
    run("illegal", 7'b0000000, 3'd0, 32'd0, 32'd0, -1);
`ifdef MCCTRL_MEMWAIT_EN
    fetch_wait = 3;
    run("fetch_wait3", OP_R, 3'd0, 32'd1, 32'd1, -1);
    fetch_wait = -1;
`endif
    // abort a store while it is in MEMWRITE
    run("sw_pre", OP_SW, 3'd2, 32'd0, 32'd0, 3);
`ifdef MCCTRL_MEMWAIT_EN
    bus.mem_ready = 1'b1;
`endif
    chk("sw_memwrite", outv, v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    reset = 1'b1;
    #1;
    chk("rst_mid_sw", outv, v(0, 0, 0, 0, 0, RES_ALURES, SRCA_PC, SRCB_FOUR, ALU_ADD, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    run("after_rst", OP_R, 3'd0, 32'd0, 32'd0, -1);
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 1) b[31] = ~b[31];
      case ($urandom_range(0, 7))
        0: opc = OP_LW;
        1: opc = OP_SW;
        2: opc = OP_R;
        3: opc = OP_I;
        4, 5: opc = OP_BR;
        6: opc = ($urandom_range(0, 1) == 1) ? OP_JAL : OP_JALR;
        default: begin
          opc = 7'($urandom);
          while (known(opc)) opc = 7'($urandom);
        end
      endcase
      run("rand", opc, 3'($urandom), a, b, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
